// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers and neuron FSM state encoding.
// Helpers work on a wide signed container; callers pass the target width.
package fixed_point_pkg;

    localparam int unsigned CALC_W = 64;
    localparam logic signed [CALC_W-1:0] CALC_ONE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        FINISH = 2'd2
    } neuron_state_e;

    // Clamp a signed value to the range of a signed width-bit number.
    function automatic logic signed [CALC_W-1:0] saturate(
        input logic signed [CALC_W-1:0] value,
        input int unsigned              width
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (CALC_ONE <<< (width - 1)) - CALC_ONE;
        lo = -(CALC_ONE <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // Negative values become zero; the rest are returned in the low width bits.
    function automatic logic signed [CALC_W-1:0] relu(
        input logic signed [CALC_W-1:0] value,
        input int unsigned              width
    );
        logic signed [CALC_W-1:0] mask;
        mask = (CALC_ONE <<< width) - CALC_ONE;
        if (value < 0) begin
            return '0;
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/neuron_if.sv
// Start/done handshake and data bus between a layer controller and one neuron.
interface neuron_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_INPUTS = 10
);

    logic                                 start;
    logic [NUM_INPUTS-1:0][DATA_W-1:0]    inputs;
    logic                                 busy;
    logic                                 done;
    logic [DATA_W-1:0]                    out;

    modport master (
        output start,
        output inputs,
        input  busy,
        input  done,
        input  out
    );

    modport slave (
        input  start,
        input  inputs,
        output busy,
        output done,
        output out
    );

endinterface

// File: rtl/weight_rom.sv
// Read-only weight store with a registered output; contents come from a packed
// parameter where word k occupies bits [k*DATA_W +: DATA_W].
module weight_rom #(
    parameter int unsigned               DATA_W   = 16,
    parameter int unsigned               DEPTH    = 10,
    parameter int unsigned               ADDR_W   = 4,
    parameter logic [DEPTH*DATA_W-1:0]   CONTENTS = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] word;

    // Address decode; unused addresses read as zero.
    always_comb begin
        word = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (address == ADDR_W'(i)) begin
                word = CONTENTS[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= word;
        end
    end

endmodule

// File: rtl/neuron.sv
// Single fixed-point neuron: sequential multiply-accumulate over the weight ROM,
// then bias, saturation and ReLU into a registered output with a done pulse.
module neuron
    import fixed_point_pkg::*;
#(
    parameter int unsigned INT_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH = 8,
    parameter int unsigned NUM_INPUTS = 10,
    parameter logic [NUM_INPUTS*(INT_WIDTH+FRAC_WIDTH)-1:0] WEIGHTS = '0,
    parameter int          BIAS       = 0
) (
    input  logic     clock,
    input  logic     reset,
    neuron_if.slave  bus
);

    localparam int unsigned DATA_W = INT_WIDTH + FRAC_WIDTH;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(NUM_INPUTS);
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned CNT_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned STEP_W = $clog2(NUM_INPUTS + 1);

    localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(NUM_INPUTS - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_INPUTS);

    // Bias is in data format; align it to the product's doubled fraction.
    localparam logic signed [SUM_W-1:0] BIAS_ALIGNED = SUM_W'(BIAS) <<< FRAC_WIDTH;

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_MAC    = 2'(MAC);
    localparam logic [1:0] S_FINISH = 2'(FINISH);

    logic [1:0]               state;
    logic [1:0]               state_next;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         kidx;
    logic [STEP_W-1:0]        step;
    logic signed [ACC_W-1:0]  acc;
    logic [DATA_W-1:0]        weight;

    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;
    logic signed [CALC_W-1:0] sat;
    logic [DATA_W-1:0]        result;

    weight_rom #(
        .DATA_W   (DATA_W),
        .DEPTH    (NUM_INPUTS),
        .ADDR_W   (CNT_W),
        .CONTENTS (WEIGHTS)
    ) u_rom (
        .clock   (clock),
        .reset   (reset),
        .address (count),
        .out     (weight)
    );

    // kidx trails count by one cycle so it names the input matching the ROM output.
    assign prod    = $signed(bus.inputs[kidx]) * $signed(weight);
    assign sum     = SUM_W'(acc) + BIAS_ALIGNED;
    assign shifted = sum >>> FRAC_WIDTH;
    assign sat     = saturate(CALC_W'(shifted), DATA_W);
    assign result  = DATA_W'(relu(sat, DATA_W));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (step == LAST_STEP) begin
                    state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Step 0 only primes the ROM; steps 1..NUM_INPUTS each accumulate one product.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            kidx     <= '0;
            step     <= '0;
            acc      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.out  <= '0;
        end else begin
            state    <= state_next;
            kidx     <= count;
            bus.busy <= (state_next != S_IDLE);
            bus.done <= (state == S_FINISH);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc   <= '0;
                        count <= '0;
                        step  <= '0;
                    end
                end
                S_MAC: begin
                    step <= step + STEP_W'(1);
                    if (count != LAST_ADDR) begin
                        count <= count + CNT_W'(1);
                    end
                    if (step != '0) begin
                        acc <= acc + ACC_W'(prod);
                    end
                end
                S_FINISH: begin
                    bus.out <= result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron.sv
// Directed and randomized checks of several neuron configurations against a
// plain-arithmetic dot-product model.
module tb_neuron;

    localparam int unsigned W = 16;

    localparam logic [3*W-1:0] WA = {16'hFF80, 16'h0200, 16'h0100};
    localparam logic [3*W-1:0] WB = {16'h0100, 16'h0100, 16'h0100};
    localparam logic [3*W-1:0] WC = {16'h7F00, 16'h7F00, 16'h7F00};
    localparam logic [1*W-1:0] WD = 16'h0080;
    localparam logic [5*W-1:0] WE = {16'h0040, 16'hFE00, 16'h0180, 16'hFFC0, 16'h0300};
    localparam int BA = 128;
    localparam int BB = 0;
    localparam int BC = 0;
    localparam int BD = 0;
    localparam int BE = -64;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    neuron_if #(.DATA_W(W), .NUM_INPUTS(3)) ia ();
    neuron_if #(.DATA_W(W), .NUM_INPUTS(3)) ib ();
    neuron_if #(.DATA_W(W), .NUM_INPUTS(3)) ic ();
    neuron_if #(.DATA_W(W), .NUM_INPUTS(1)) id ();
    neuron_if #(.DATA_W(W), .NUM_INPUTS(5)) ie ();

    neuron #(.INT_WIDTH(8), .FRAC_WIDTH(8), .NUM_INPUTS(3), .WEIGHTS(WA), .BIAS(BA))
        dut_a (.clock(clock), .reset(reset), .bus(ia));
    neuron #(.INT_WIDTH(8), .FRAC_WIDTH(8), .NUM_INPUTS(3), .WEIGHTS(WB), .BIAS(BB))
        dut_b (.clock(clock), .reset(reset), .bus(ib));
    neuron #(.INT_WIDTH(8), .FRAC_WIDTH(8), .NUM_INPUTS(3), .WEIGHTS(WC), .BIAS(BC))
        dut_c (.clock(clock), .reset(reset), .bus(ic));
    neuron #(.INT_WIDTH(8), .FRAC_WIDTH(8), .NUM_INPUTS(1), .WEIGHTS(WD), .BIAS(BD))
        dut_d (.clock(clock), .reset(reset), .bus(id));
    neuron #(.INT_WIDTH(8), .FRAC_WIDTH(8), .NUM_INPUTS(5), .WEIGHTS(WE), .BIAS(BE))
        dut_e (.clock(clock), .reset(reset), .bus(ie));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input int which);
        case (which)
            3:       return 1;
            4:       return 5;
            default: return 3;
        endcase
    endfunction

    function automatic logic get_done(input int which);
        case (which)
            0:       return ia.done;
            1:       return ib.done;
            2:       return ic.done;
            3:       return id.done;
            default: return ie.done;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            0:       return ia.busy;
            1:       return ib.busy;
            2:       return ic.busy;
            3:       return id.busy;
            default: return ie.busy;
        endcase
    endfunction

    function automatic logic [W-1:0] get_out(input int which);
        case (which)
            0:       return ia.out;
            1:       return ib.out;
            2:       return ic.out;
            3:       return id.out;
            default: return ie.out;
        endcase
    endfunction

    task automatic set_start(input int which, input logic s);
        case (which)
            0:       ia.start = s;
            1:       ib.start = s;
            2:       ic.start = s;
            3:       id.start = s;
            default: ie.start = s;
        endcase
    endtask

    task automatic set_inputs(input int which, input logic [4:0][W-1:0] ins);
        case (which)
            0:       ia.inputs = ins[2:0];
            1:       ib.inputs = ins[2:0];
            2:       ic.inputs = ins[2:0];
            3:       id.inputs = ins[0:0];
            default: ie.inputs = ins;
        endcase
    endtask

    // Reference: exact dot product, bias, floor-shift, clamp to int16, ReLU.
    function automatic logic [W-1:0] model(input int which, input logic [4:0][W-1:0] ins);
        logic [5*W-1:0] wv;
        logic [W-1:0]   wi;
        int             bias;
        longint         s;
        case (which)
            0:       begin wv = 80'(WA); bias = BA; end
            1:       begin wv = 80'(WB); bias = BB; end
            2:       begin wv = 80'(WC); bias = BC; end
            3:       begin wv = 80'(WD); bias = BD; end
            default: begin wv = WE;      bias = BE; end
        endcase
        s = 0;
        for (int i = 0; i < n_of(which); i++) begin
            wi = wv[i*W +: W];
            s += longint'($signed(ins[i])) * longint'($signed(wi));
        end
        s += longint'(bias) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (s < 0) s = 0;
        return W'(s);
    endfunction

    task automatic run_tx(input string tag, input int which, input logic [4:0][W-1:0] ins,
                          input logic [W-1:0] exp, input int extra_at);
        int n;
        int done_at;
        bit busy_ok;
        n       = n_of(which);
        done_at = -1;
        busy_ok = 1'b1;
        @(negedge clock);
        set_inputs(which, ins);
        set_start(which, 1'b1);
        @(posedge clock);
        #1;
        set_start(which, 1'b0);
        for (int c = 0; c < n + 8 && done_at < 0; c++) begin
            if (c > 0) begin
                @(posedge clock);
                #1;
            end
            if (extra_at > 0 && c == extra_at - 1) set_start(which, 1'b1);
            if (extra_at > 0 && c == extra_at) set_start(which, 1'b0);
            if (get_done(which)) done_at = c;
            else if (!get_busy(which)) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 32'(done_at), 32'(n + 2));
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_busy_at_done"}, 32'(get_busy(which)), 32'd0);
        check({tag, "_out"}, 32'(get_out(which)), 32'(exp));
        @(posedge clock);
        #1;
        check({tag, "_done_pulse"}, 32'(get_done(which)), 32'd0);
    endtask

    initial begin
        logic [4:0][W-1:0] v;
        logic [4:0][W-1:0] c1;
        bit                quiet;
        int                which;
        logic [31:0]       r;

        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            v = '0;
            set_inputs(k, v);
            set_start(k, 1'b0);
        end
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_a", 32'(ia.out), 32'd0);
        check("rst_busy_a", 32'(ia.busy), 32'd0);
        check("rst_done_a", 32'(ia.done), 32'd0);
        check("rst_out_e", 32'(ie.out), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        c1 = '0;
        c1[0] = 16'h0100;
        c1[1] = 16'h0100;
        c1[2] = 16'h0200;
        run_tx("case1", 0, c1, 16'h0280, 0);

        v = '0;
        v[0] = 16'hFF00;
        v[1] = 16'hFE00;
        v[2] = 16'h0080;
        run_tx("case2_relu", 1, v, 16'h0000, 0);

        v = '0;
        v[0] = 16'h7F00;
        v[1] = 16'h7F00;
        v[2] = 16'h7F00;
        run_tx("case3_sat", 2, v, 16'h7FFF, 0);

        v = '0;
        v[0] = 16'h0001;
        run_tx("case4_trunc", 3, v, 16'h0000, 0);

        run_tx("case5_ignored_start", 0, c1, 16'h0280, 2);
        run_tx("case5_back_to_back", 0, c1, 16'h0280, 0);

        // Reset in the middle of MAC: everything clears and no done follows.
        @(negedge clock);
        ia.start = 1'b1;
        @(posedge clock);
        #1;
        ia.start = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("case6_out_cleared", 32'(ia.out), 32'd0);
        check("case6_busy_cleared", 32'(ia.busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (ia.done || ia.busy) quiet = 1'b0;
        end
        check("case6_no_done", 32'(quiet), 32'd1);
        run_tx("case6_restart", 0, c1, 16'h0280, 0);

        for (int t = 0; t < 40; t++) begin
            which = int'($urandom_range(0, 4));
            v = '0;
            for (int i = 0; i < 5; i++) begin
                r = $urandom;
                if (r[0]) v[i] = W'($urandom);
                else v[i] = W'($urandom_range(0, 16'h0800)) - 16'h0400;
            end
            run_tx($sformatf("rand%0d_n%0d", t, which), which, v, model(which, v), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
